control_unit: RTL and testbench
===============================

# control_unit

Multicycle control FSM for the 16-bit processor. It fetches instructions from instruction memory, decodes them, and sequences the register file, data memory and 16-bit ALU through fetch/decode/execute cycles. It produces the ALU function select, register-file addresses and strobes, data-memory address and write strobe, and the write-back mux select. It contains no datapath arithmetic except the program counter.

## Interface
- Bits, 16, datapath/instruction width; only 16 is supported because the instruction format depends on it.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- IrData  in  16  instruction memory read data for PcAddr; combinational read.
- RpZero  in  1  high when the register-file Rp read port value equals 0.
- PcAddr  out  8  program counter, driving instruction memory.
- DAddr  out  8  data memory address.
- DWr  out  1  data memory write strobe.
- RFWAddr  out  4  register-file write address.
- RFWr  out  1  register-file write strobe.
- RFRpAddr / RFRqAddr  out  4 each  register-file read addresses (Rp feeds ALU A, Rq feeds ALU B).
- RFWrSel  out  2  write-back source: 0 = ALU Q, 1 = data memory, 2 = Imm zero-extended.
- Imm  out  8  IR[7:0].
- ALUSel  out  3  ALU function: 0 = zero, 1 = add, 2 = sub, 3 = pass A, 4 = xor, 5 = or, 6 = and, 7 = A+1.
- Halted  out  1  high while in HALT.
- StateOut  out  4  current state encoding, for debug.

## Operation
- Internal registers: 16-bit IR, 8-bit PC, and the state.
- Instruction format: op = IR[15:12], Ra = IR[11:8], then either Rb = IR[7:4] and Rc = IR[3:0], or addr = IR[7:0].
- Opcodes:
  - 0 NOOP.
  - 1 LOAD: Ra <- DM[addr].
  - 2 STORE: DM[addr] <- Ra.
  - 3 ADD, 4 SUB, 5 XOR, 6 OR, 7 AND: Ra <- Rb op Rc.
  - 8 INC: Ra <- Rb+1.
  - 9 MOV: Ra <- Rb.
  - A LDI: Ra <- {8'h00, addr}.
  - B JZ: if Ra == 0 then PC <- addr.
  - F HALT.
  - C, D, E execute as NOOP.
- States and encodings: INIT = 0, FETCH = 1, DECODE = 2, LOAD_A = 3, LOAD_B = 4, STORE = 5, ALU_EX = 6, LDI = 7, JZ = 8, HALT = 9.
- INIT: all strobes low; next state is FETCH.
- FETCH: IR <- IrData and PC <- PC+1 (8-bit, 8'hFF wraps to 8'h00); next state is DECODE.
- DECODE: branches on op. NOOP and unused opcodes go to FETCH. LOAD -> LOAD_A, STORE -> STORE, opcodes 3-9 -> ALU_EX, LDI -> LDI, JZ -> JZ, HALT -> HALT.
- LOAD_A: DAddr = addr; next state LOAD_B. Data memory has a 1-cycle synchronous read.
- LOAD_B: DAddr = addr, RFWAddr = Ra, RFWrSel = 1, RFWr = 1; next state FETCH.
- STORE: DAddr = addr, RFRpAddr = Ra, DWr = 1; next state FETCH.
- ALU_EX: RFRpAddr = Rb, RFRqAddr = Rc, RFWAddr = Ra, RFWrSel = 0, RFWr = 1. ALUSel = 1, 2, 4, 5, 6, 7, 3 for ADD, SUB, XOR, OR, AND, INC, MOV respectively. Next state FETCH.
- LDI: RFWAddr = Ra, RFWrSel = 2, RFWr = 1; next state FETCH.
- JZ: RFRpAddr = Ra. If RpZero, PC <- addr at the clock edge. Next state FETCH.
- HALT: Halted = 1 and no strobes. The block stays in HALT until Reset.
- Outputs are Moore-decoded from state and IR. In any state where a field is unused, the output is 0: DWr, RFWr, RFWrSel, ALUSel and the addresses all drive 0. Imm always equals IR[7:0].
- Reset forces DWr and RFWr low combinationally in the same cycle, so a reset asserted mid-instruction never completes a write.

## Timing
- On a clock edge with Reset high: state = INIT, PC = 0, IR = 0. All outputs are then 0 (StateOut = 0, Halted = 0).
- After Reset is released: INIT (1 cycle), then FETCH. The first instruction comes from address 0.
- Cycles per instruction, counting FETCH:
  - NOOP/unused: 2.
  - ALU, STORE, LDI, JZ: 3.
  - LOAD: 4.
- Register-file writes occur at the clock edge that ends ALU_EX, LDI or LOAD_B. The memory write occurs at the edge ending STORE.
- JZ samples RpZero during the JZ state. Its PC update overrides the FETCH increment already taken, so the next FETCH uses addr.
- IrData is sampled only at the edge ending FETCH. IrData changes in other states are ignored.
- A JZ to the PC of its own successor behaves identically taken or not. A JZ to itself loops forever without error.

## Test plan
- Reset held 2 cycles, then released, with IrData = 16'h0000 -> all outputs 0 during reset. StateOut sequence after release is 0,1,2,1,2; PcAddr steps 0,1,2.
- IrData = 16'h3412 (ADD R4 = R1+R2) -> in the 3rd post-FETCH cycle, ALUSel = 1, RFRpAddr = 1, RFRqAddr = 2, RFWAddr = 4, RFWrSel = 0, RFWr = 1 for exactly one cycle.
- IrData = 16'h1530 (LOAD R5 <- DM[30h]) -> DAddr = 8'h30 for 2 cycles. RFWr = 1 only in LOAD_B, with RFWrSel = 1 and RFWAddr = 5. Next FETCH is 4 cycles after the previous one.
- IrData = 16'hB2C0 (JZ R2, C0h): with RpZero = 1, the next PcAddr is 8'hC0; with RpZero = 0, it is the old PC+1. Preload PC = 8'hFF via JZ to confirm FETCH wraps to 8'h00.
- IrData = 16'h2377 (STORE), Reset asserted during the STORE state -> DWr stays 0 that cycle; next state is INIT with PC = 0.
- IrData = 16'hF000 -> Halted = 1 and StateOut = 9 indefinitely, with PcAddr frozen. Reset returns the block to INIT.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle control FSM for the 16-bit processor: fetches from instruction
// memory, decodes, and sequences register file, data memory and ALU.
module control_unit #(
  parameter int BITS = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [BITS-1:0] ir_data_i,
  input  logic            rp_zero_i,
  output logic [7:0]      pc_addr_o,
  output logic [7:0]      d_addr_o,
  output logic            d_wr_o,
  output logic [3:0]      rf_w_addr_o,
  output logic            rf_wr_o,
  output logic [3:0]      rf_rp_addr_o,
  output logic [3:0]      rf_rq_addr_o,
  output logic [1:0]      rf_wr_sel_o,
  output logic [7:0]      imm_o,
  output logic [2:0]      alu_sel_o,
  output logic            halted_o,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ALU_EX = 4'd6,
    S_LDI    = 4'd7,
    S_JZ     = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_INC   = 4'h8;
  localparam logic [3:0] OP_MOV   = 4'h9;
  localparam logic [3:0] OP_LDI   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_DMEM = 2'd1;
  localparam logic [1:0] WSEL_IMM  = 2'd2;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  state_e          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [BITS-1:0] ir_q, ir_d;

  logic [3:0] op, ra, rb, rc;
  logic [7:0] addr;

  assign op   = ir_q[15:12];
  assign ra   = ir_q[11:8];
  assign rb   = ir_q[7:4];
  assign rc   = ir_q[3:0];
  assign addr = ir_q[7:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_INIT;
      pc_q    <= 8'h00;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, PC and IR. A taken JZ overwrites the increment made in FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = ir_data_i;
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD:  state_d = S_LOAD_A;
          OP_STORE: state_d = S_STORE;
          OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC, OP_MOV:
                    state_d = S_ALU_EX;
          OP_LDI:   state_d = S_LDI;
          OP_JZ:    state_d = S_JZ;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ALU_EX: state_d = S_FETCH;
      S_LDI:    state_d = S_FETCH;
      S_JZ: begin
        if (rp_zero_i) pc_d = addr;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  logic       d_wr, rf_wr;
  logic [7:0] d_addr;
  logic [3:0] rf_w_addr, rf_rp_addr, rf_rq_addr;
  logic [1:0] rf_wr_sel;
  logic [2:0] alu_sel;

  // Moore outputs; every field not used by the current state drives zero.
  always_comb begin
    d_wr       = 1'b0;
    rf_wr      = 1'b0;
    d_addr     = 8'h00;
    rf_w_addr  = 4'h0;
    rf_rp_addr = 4'h0;
    rf_rq_addr = 4'h0;
    rf_wr_sel  = WSEL_ALU;
    alu_sel    = ALU_ZERO;
    case (state_q)
      S_LOAD_A: d_addr = addr;
      S_LOAD_B: begin
        d_addr    = addr;
        rf_w_addr = ra;
        rf_wr_sel = WSEL_DMEM;
        rf_wr     = 1'b1;
      end
      S_STORE: begin
        d_addr     = addr;
        rf_rp_addr = ra;
        d_wr       = 1'b1;
      end
      S_ALU_EX: begin
        rf_rp_addr = rb;
        rf_rq_addr = rc;
        rf_w_addr  = ra;
        rf_wr_sel  = WSEL_ALU;
        rf_wr      = 1'b1;
        case (op)
          OP_ADD:  alu_sel = ALU_ADD;
          OP_SUB:  alu_sel = ALU_SUB;
          OP_XOR:  alu_sel = ALU_XOR;
          OP_OR:   alu_sel = ALU_OR;
          OP_AND:  alu_sel = ALU_AND;
          OP_INC:  alu_sel = ALU_INC;
          OP_MOV:  alu_sel = ALU_PASS;
          default: alu_sel = ALU_ZERO;
        endcase
      end
      S_LDI: begin
        rf_w_addr = ra;
        rf_wr_sel = WSEL_IMM;
        rf_wr     = 1'b1;
      end
      S_JZ:    rf_rp_addr = ra;
      default: ;
    endcase
  end

  // Reset kills the strobes immediately so an interrupted instruction never writes.
  assign d_wr_o       = d_wr & ~reset_i;
  assign rf_wr_o      = rf_wr & ~reset_i;
  assign d_addr_o     = d_addr;
  assign rf_w_addr_o  = rf_w_addr;
  assign rf_rp_addr_o = rf_rp_addr;
  assign rf_rq_addr_o = rf_rq_addr;
  assign rf_wr_sel_o  = rf_wr_sel;
  assign alu_sel_o    = alu_sel;
  assign pc_addr_o    = pc_q;
  assign imm_o        = ir_q[7:0];
  assign halted_o     = (state_q == S_HALT);
  assign state_o      = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction memory model, write-event
// scoreboard, and per-feature directed and random program tests.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir_data;
  logic        rp_zero = 1'b0;
  logic [7:0]  pc_addr, d_addr, imm;
  logic        d_wr, rf_wr, halted;
  logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr, state;
  logic [1:0]  rf_wr_sel;
  logic [2:0]  alu_sel;

  logic [15:0] imem [256];
  logic [26:0] exp_q [$];
  logic [26:0] obs_w, exp_w;
  logic [47:0] all_outs;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_unit #(.BITS(16)) dut (
    .clk_i(clk), .reset_i(reset), .ir_data_i(ir_data), .rp_zero_i(rp_zero),
    .pc_addr_o(pc_addr), .d_addr_o(d_addr), .d_wr_o(d_wr),
    .rf_w_addr_o(rf_w_addr), .rf_wr_o(rf_wr), .rf_rp_addr_o(rf_rp_addr),
    .rf_rq_addr_o(rf_rq_addr), .rf_wr_sel_o(rf_wr_sel), .imm_o(imm),
    .alu_sel_o(alu_sel), .halted_o(halted), .state_o(state)
  );

  assign ir_data  = imem[pc_addr];
  assign all_outs = {state, pc_addr, halted, d_wr, rf_wr, d_addr, rf_w_addr,
                     rf_rp_addr, rf_rq_addr, rf_wr_sel, imm, alu_sel};

  function automatic logic [26:0] wr_word(logic [1:0] kind, logic [2:0] alu,
      logic [3:0] rp, logic [3:0] rq, logic [3:0] wa, logic [1:0] wsel, logic [7:0] da);
    return {kind, alu, rp, rq, wa, wsel, da};
  endfunction

  function automatic logic [2:0] alu_of(logic [3:0] op);
    case (op)
      4'h3: return 3'd1;
      4'h4: return 3'd2;
      4'h5: return 3'd4;
      4'h6: return 3'd5;
      4'h7: return 3'd6;
      4'h8: return 3'd7;
      4'h9: return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  // Scoreboard: every write strobe seen must match the next expected event.
  always @(negedge clk) begin
    #2;
    if (rf_wr || d_wr) begin
      obs_w = {d_wr, rf_wr, alu_sel, rf_rp_addr, rf_rq_addr, rf_w_addr, rf_wr_sel, d_addr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got=%h exp=none", obs_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (obs_w !== exp_w) begin
          errors++;
          $display("FAIL write_event got=%h exp=%h", obs_w, exp_w);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic start_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_queue_empty(string name);
    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int es [5] = '{0, 1, 2, 1, 2};
    int ep [5] = '{0, 0, 1, 1, 2};
    clear_mem();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if (all_outs !== 48'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got=%h exp=0", i, all_outs);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      checks++;
      if (state !== 4'(es[i]) || pc_addr !== 8'(ep[i])) begin
        errors++;
        $display("FAIL reset_seq[%0d] got=%0d/%0d exp=%0d/%0d", i, state, pc_addr, es[i], ep[i]);
      end
    end
  endtask

  task automatic test_add();
    int es [7] = '{0, 1, 2, 6, 1, 2, 9};
    int ew [7] = '{0, 0, 0, 1, 0, 0, 0};
    start_reset();
    clear_mem();
    imem[0] = 16'h3412;
    imem[1] = 16'hF000;
    exp_q.push_back(wr_word(2'b01, 3'd1, 4'd1, 4'd2, 4'd4, 2'd0, 8'h00));
    release_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      checks++;
      if (state !== 4'(es[i]) || rf_wr !== 1'(ew[i])) begin
        errors++;
        $display("FAIL add_cycle[%0d] got=%0d/%b exp=%0d/%0d", i, state, rf_wr, es[i], ew[i]);
      end
      if (i == 3) begin
        checks++;
        if (imm !== 8'h12 || alu_sel !== 3'd1) begin
          errors++;
          $display("FAIL add_imm_alu got=%h/%0d exp=12/1", imm, alu_sel);
        end
      end
    end
    check_queue_empty("add");
  endtask

  task automatic test_load();
    int es [8] = '{0, 1, 2, 3, 4, 1, 2, 9};
    int ed [8] = '{0, 0, 0, 8'h30, 8'h30, 0, 0, 0};
    int ew [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    start_reset();
    clear_mem();
    imem[0] = 16'h1530;
    imem[1] = 16'hF000;
    exp_q.push_back(wr_word(2'b01, 3'd0, 4'd0, 4'd0, 4'd5, 2'd1, 8'h30));
    release_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      checks++;
      if (state !== 4'(es[i]) || d_addr !== 8'(ed[i]) || rf_wr !== 1'(ew[i])) begin
        errors++;
        $display("FAIL load_cycle[%0d] got=%0d/%h/%b exp=%0d/%h/%0d",
                 i, state, d_addr, rf_wr, es[i], ed[i], ew[i]);
      end
    end
    check_queue_empty("load");
  endtask

  task automatic test_jz();
    logic [7:0] exp_pc;
    for (int t = 0; t < 2; t++) begin
      start_reset();
      clear_mem();
      imem[0] = 16'hB2C0;
      imem[1] = 16'hF000;
      imem[8'hC0] = 16'hF000;
      rp_zero = (t == 0);
      exp_pc = (t == 0) ? 8'hC0 : 8'h01;
      release_reset();
      for (int i = 0; i < 5; i++) begin
        if (i > 0) next_cycle();
        if (i == 3) begin
          checks++;
          if (state !== 4'd8 || rf_rp_addr !== 4'd2) begin
            errors++;
            $display("FAIL jz_state[%0d] got=%0d/%0d exp=8/2", t, state, rf_rp_addr);
          end
        end
      end
      checks++;
      if (state !== 4'd1 || pc_addr !== exp_pc) begin
        errors++;
        $display("FAIL jz_target[%0d] got=%0d/%h exp=1/%h", t, state, pc_addr, exp_pc);
      end
    end
    // Jump to 8'hFF, then FETCH there must wrap the PC to 8'h00.
    start_reset();
    clear_mem();
    imem[0] = 16'hB0FF;
    rp_zero = 1'b1;
    release_reset();
    for (int i = 1; i <= 4; i++) next_cycle();
    checks++;
    if (pc_addr !== 8'hFF) begin
      errors++;
      $display("FAIL jz_preload got=%h exp=ff", pc_addr);
    end
    next_cycle();
    checks++;
    if (state !== 4'd2 || pc_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap got=%0d/%h exp=2/00", state, pc_addr);
    end
    // JZ to itself keeps looping through FETCH at address 0.
    start_reset();
    clear_mem();
    imem[0] = 16'hB000;
    release_reset();
    for (int i = 1; i <= 7; i++) next_cycle();
    checks++;
    if (state !== 4'd1 || pc_addr !== 8'h00) begin
      errors++;
      $display("FAIL jz_self got=%0d/%h exp=1/00", state, pc_addr);
    end
    rp_zero = 1'b0;
  endtask

  task automatic test_store_reset();
    start_reset();
    clear_mem();
    imem[0] = 16'h2377;
    release_reset();
    for (int i = 1; i <= 3; i++) next_cycle();
    checks++;
    if (state !== 4'd5 || d_wr !== 1'b1 || d_addr !== 8'h77 || rf_rp_addr !== 4'd3) begin
      errors++;
      $display("FAIL store_state got=%0d/%b/%h/%0d exp=5/1/77/3", state, d_wr, d_addr, rf_rp_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (d_wr !== 1'b0 || rf_wr !== 1'b0) begin
      errors++;
      $display("FAIL store_reset_gate got=%b/%b exp=0/0", d_wr, rf_wr);
    end
    next_cycle();
    checks++;
    if (state !== 4'd0 || pc_addr !== 8'h00) begin
      errors++;
      $display("FAIL store_reset_after got=%0d/%h exp=0/00", state, pc_addr);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    start_reset();
    clear_mem();
    imem[0] = 16'hF000;
    release_reset();
    for (int i = 1; i <= 3; i++) next_cycle();
    imem[1] = 16'h3412;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (state !== 4'd9 || halted !== 1'b1 || pc_addr !== 8'h01) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL halt_hold[%0d] got=%0d/%b/%h exp=9/1/01", i, state, halted, pc_addr);
      end
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || pc_addr !== 8'h00) begin
      errors++;
      $display("FAIL halt_reset got=%0d/%b/%h exp=0/0/00", state, halted, pc_addr);
    end
  endtask

  task automatic test_back_to_back();
    int sum = 0;
    int idx = -1;
    logic [3:0] op, ra;
    logic [7:0] lo;
    start_reset();
    clear_mem();
    rp_zero = 1'b0;
    for (int k = 0; k < 16; k++) begin
      op = 4'($urandom_range(0, 14));
      ra = 4'($urandom_range(0, 15));
      lo = 8'($urandom_range(0, 255));
      imem[k] = {op, ra, lo};
      case (op)
        4'h1: begin
          sum += 4;
          exp_q.push_back(wr_word(2'b01, 3'd0, 4'd0, 4'd0, ra, 2'd1, lo));
        end
        4'h2: begin
          sum += 3;
          exp_q.push_back(wr_word(2'b10, 3'd0, ra, 4'd0, 4'd0, 2'd0, lo));
        end
        4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          sum += 3;
          exp_q.push_back(wr_word(2'b01, alu_of(op), lo[7:4], lo[3:0], ra, 2'd0, 8'h00));
        end
        4'hA: begin
          sum += 3;
          exp_q.push_back(wr_word(2'b01, 3'd0, 4'd0, 4'd0, ra, 2'd2, 8'h00));
        end
        4'hB: sum += 3;
        default: sum += 2;
      endcase
    end
    imem[16] = 16'hF000;
    release_reset();
    for (int c = 0; c < 400; c++) begin
      if (state == 4'd9) begin
        idx = c;
        break;
      end
      next_cycle();
    end
    checks++;
    if (idx !== sum + 3) begin
      errors++;
      $display("FAIL b2b_halt_cycle got=%0d exp=%0d", idx, sum + 3);
    end
    check_queue_empty("b2b");
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_add();
    test_load();
    test_jz();
    test_store_reset();
    test_halt();
    for (int r = 0; r < 4; r++) test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
